// File: rtl/cmac_lbus_rx_flu.sv
// CMAC LBUS RX (4x128b segments) to 512b FrameLinkUnaligned store-and-forward adapter.
// Statistics counters are built only when CMAC_RX_FLU_STATS_EN is defined.
module cmac_lbus_rx_flu #(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [511:0]         RX_LBUS_DATA,
  input  logic [3:0]           RX_LBUS_ENA,
  input  logic [3:0]           RX_LBUS_SOP,
  input  logic [3:0]           RX_LBUS_EOP,
  input  logic [3:0]           RX_LBUS_ERR,
  input  logic [15:0]          RX_LBUS_MTY,
  output logic [511:0]         TX_DATA,
  output logic [2:0]           TX_SOP_POS,
  output logic [5:0]           TX_EOP_POS,
  output logic                 TX_SOP,
  output logic                 TX_EOP,
  output logic                 TX_SRC_RDY,
  input  logic                 TX_DST_RDY,
  input  logic                 STAT_CLEAR,
  output logic [CNT_WIDTH-1:0] STAT_FRAMES_OK,
  output logic [CNT_WIDTH-1:0] STAT_FRAMES_ERR,
  output logic [CNT_WIDTH-1:0] STAT_FRAMES_OVF
);
  localparam int SEGS = 4 * FIFO_DEPTH;
  localparam int AW   = $clog2(SEGS);
  localparam int PW   = AW + 1;
  localparam int RW   = AW - 2;
  localparam int EW   = 134;
  localparam logic [PW-1:0] ONE = PW'(1);

  // Entry layout: [133] sop, [132] eop, [131:128] mty, [127:0] LBUS segment data.
  logic [EW-1:0] mem_q [4][FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, frame_start_q, frame_start_d;
  logic          open_q, open_d, flag_q, flag_d;
  logic [3:0]    we;
  logic [RW-1:0] waddr [4];
  logic [EW-1:0] wdata [4];
  logic [2:0]    ok_inc, err_inc, ovf_inc;

  logic          src_rdy_q, src_rdy_d, sop_q, sop_d, eop_q, eop_d;
  logic [5:0]    eop_pos_q, eop_pos_d;
  logic [511:0]  data_q, data_d;
  logic [PW-1:0] avail, rp;
  logic [EW-1:0] rseg;
  logic          done;

  // Segments are processed in order so a rollback in segment i is visible to segment i+1.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    frame_start_d = frame_start_q;
    open_d        = open_q;
    flag_d        = flag_q;
    we            = '0;
    ok_inc        = '0;
    err_inc       = '0;
    ovf_inc       = '0;
    for (int b = 0; b < 4; b++) begin
      waddr[b] = '0;
      wdata[b] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (RX_LBUS_ENA[i]) begin
        if (RX_LBUS_SOP[i]) begin
          if (open_d) begin
            wr_ptr_d = frame_start_d;
            err_inc  = err_inc + 3'd1;
          end
          frame_start_d = wr_ptr_d;
          open_d        = 1'b1;
          flag_d        = 1'b0;
        end
        if (open_d) begin
          if ((wr_ptr_d[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_d[AW-1:0] == rd_ptr_q[AW-1:0]))
            flag_d = 1'b1;
          if (!flag_d) begin
            we[wr_ptr_d[1:0]]    = 1'b1;
            waddr[wr_ptr_d[1:0]] = wr_ptr_d[AW-1:2];
            wdata[wr_ptr_d[1:0]] = {RX_LBUS_SOP[i], RX_LBUS_EOP[i], RX_LBUS_MTY[4*i +: 4],
                                    RX_LBUS_DATA[128*i +: 128]};
            wr_ptr_d = wr_ptr_d + ONE;
          end
          if (RX_LBUS_EOP[i]) begin
            if (RX_LBUS_ERR[i]) begin
              wr_ptr_d = frame_start_d;
              err_inc  = err_inc + 3'd1;
            end else if (flag_d) begin
              wr_ptr_d = frame_start_d;
              ovf_inc  = ovf_inc + 3'd1;
            end else begin
              commit_ptr_d = wr_ptr_d;
              ok_inc       = ok_inc + 3'd1;
            end
            open_d = 1'b0;
            flag_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem_q[b][waddr[b]] <= wdata[b];
  end

  // Only committed (whole) frames are visible, so a word never waits for missing segments.
  always_comb begin
    avail     = commit_ptr_q - rd_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    src_rdy_d = src_rdy_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    eop_pos_d = eop_pos_q;
    data_d    = data_q;
    rp        = '0;
    rseg      = '0;
    done      = 1'b0;
    if (!src_rdy_q || TX_DST_RDY) begin
      src_rdy_d = (avail != '0);
      sop_d     = 1'b0;
      eop_d     = 1'b0;
      eop_pos_d = '0;
      data_d    = '0;
      for (int j = 0; j < 4; j++) begin
        if (!done && (avail > PW'(j))) begin
          rp   = rd_ptr_q + PW'(j);
          rseg = mem_q[rp[1:0]][rp[AW-1:2]];
          for (int b = 0; b < 16; b++)
            data_d[128*j + 8*b +: 8] = rseg[127-8*b -: 8];
          if (j == 0) sop_d = rseg[133];
          if (rseg[132]) begin
            eop_d     = 1'b1;
            eop_pos_d = 6'(16*j + 15) - {2'b00, rseg[131:128]};
            done      = 1'b1;
          end
          rd_ptr_d = rp + ONE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      frame_start_q <= '0;
      open_q        <= 1'b0;
      flag_q        <= 1'b0;
      src_rdy_q     <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      eop_pos_q     <= '0;
      data_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_start_q <= frame_start_d;
      open_q        <= open_d;
      flag_q        <= flag_d;
      src_rdy_q     <= src_rdy_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      eop_pos_q     <= eop_pos_d;
      data_q        <= data_d;
    end
  end

  assign TX_DATA    = data_q;
  assign TX_SOP_POS = 3'd0;
  assign TX_EOP_POS = eop_pos_q;
  assign TX_SOP     = sop_q;
  assign TX_EOP     = eop_q;
  assign TX_SRC_RDY = src_rdy_q;

`ifdef CMAC_RX_FLU_STATS_EN
  logic [CNT_WIDTH-1:0] ok_q, ok_d, err_q, err_d, ovf_q, ovf_d;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [2:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    ok_d  = STAT_CLEAR ? '0 : sat_add(ok_q, ok_inc);
    err_d = STAT_CLEAR ? '0 : sat_add(err_q, err_inc);
    ovf_d = STAT_CLEAR ? '0 : sat_add(ovf_q, ovf_inc);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ok_q  <= '0;
      err_q <= '0;
      ovf_q <= '0;
    end else begin
      ok_q  <= ok_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign STAT_FRAMES_OK  = ok_q;
  assign STAT_FRAMES_ERR = err_q;
  assign STAT_FRAMES_OVF = ovf_q;
`else
  logic unused_stat;
  assign unused_stat     = ^{STAT_CLEAR, ok_inc, err_inc, ovf_inc};
  assign STAT_FRAMES_OK  = '0;
  assign STAT_FRAMES_ERR = '0;
  assign STAT_FRAMES_OVF = '0;
`endif

endmodule
